// File: rtl/sparc_mem_pkg.sv
// rtl/sparc_mem_pkg.sv - op3 codes, FSM states and access-size decode for the SPARC memory responder
// Contents:
//   OP_*       SPARC op3 values of the supported loads/stores
//   state_e    responder FSM encoding (IDLE -> BUSY -> DONE)
//   op_info_t  decoded access: valid, store/load, sign-extend, size in bytes (1/2/4)
//   decode_op  op3 -> op_info_t; unsupported op3 (incl. LDD/STD) decodes as valid=0
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       is_store;
    logic       is_signed;
    logic [2:0] size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op3);
    op_info_t info;
    info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: 3'd4};
    case (op3)
      OP_LD:   info.size = 3'd4;
      OP_LDUB: info.size = 3'd1;
      OP_LDUH: info.size = 3'd2;
      OP_LDSB: begin info.size = 3'd1; info.is_signed = 1'b1; end
      OP_LDSH: begin info.size = 3'd2; info.is_signed = 1'b1; end
      OP_ST:   begin info.size = 3'd4; info.is_store = 1'b1; end
      OP_STB:  begin info.size = 3'd1; info.is_store = 1'b1; end
      OP_STH:  begin info.size = 3'd2; info.is_store = 1'b1; end
      default: begin info.valid = 1'b0; info.size = 3'd1; end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sparc_mem_responder_if.sv
// rtl/sparc_mem_responder_if.sv - RAM handshake bundle between control unit and memory responder
// Signals:
//   RAM_enable  request valid, held by master until MFC
//   RAM_OpCode  SPARC op3 of the access
//   Address     byte address (ADDR_W bits)
//   DataIn      store data
//   DataOut     load result, valid while MFC=1
//   MFC         memory function complete
//   MISALIGN    misaligned access flag, valid while MFC=1
// Modports: master (control unit), slave (responder)
interface sparc_mem_responder_if #(
  parameter int ADDR_W = 9
);
  logic              RAM_enable;
  logic [5:0]        RAM_OpCode;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MFC;
  logic              MISALIGN;

  modport master (
    output RAM_enable, RAM_OpCode, Address, DataIn,
    input  DataOut, MFC, MISALIGN
  );

  modport slave (
    input  RAM_enable, RAM_OpCode, Address, DataIn,
    output DataOut, MFC, MISALIGN
  );
endinterface

// File: rtl/sparc_mem_byte_array.sv
// rtl/sparc_mem_byte_array.sv - byte-wide storage with four big-endian byte lanes, no reset
// Ports:
//   clk    in   write clock
//   addr   in   base byte address A; lane i addresses A+i modulo 2**ADDR_W
//   we     in   per-lane write enables, we[0] is the byte at A (most significant)
//   wdata  in   lane i data in bits [31-8i -: 8]
//   rdata  out  combinational read, {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}
module sparc_mem_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [7:0]        Mem [0:2**ADDR_W-1];
  logic [ADDR_W-1:0] lane_addr [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    // Natural ADDR_W-bit overflow gives the modulo wrap of A+1..A+3.
    assign lane_addr[i]            = addr + ADDR_W'(i);
    assign rdata[31-8*i -: 8]      = Mem[lane_addr[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) Mem[lane_addr[i]] <= wdata[31-8*i -: 8];
    end
  end
endmodule

// File: rtl/sparc_mem_responder.sv
// rtl/sparc_mem_responder.sv - wait-stated SPARC RAM responder with MFC handshake
// Optional feature macro: SPARC_MEM_ALIGN_TRAP_EN (flag misaligned half/word accesses instead of force-aligning)
// Ports:
//   Clk      in   system clock, rising edge
//   RESET_n  in   asynchronous active-low reset
//   bus      slave modport of sparc_mem_responder_if (RAM_enable/RAM_OpCode/Address/DataIn in,
//            DataOut/MFC/MISALIGN out)
// Parameters: ADDR_W (byte-address width), WAIT_STATES (0..15 cycles between capture and execute)
module sparc_mem_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  RESET_n,
  sparc_mem_responder_if.slave  bus
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              mfc_q, mfc_d;
  logic              mis_q, mis_d;

  op_info_t          info;
  logic              misalign;
  logic              exec;
  logic [ADDR_W-1:0] eff_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       load_data;

  assign info = decode_op(op_q);

`ifdef SPARC_MEM_ALIGN_TRAP_EN
  assign misalign = info.valid &&
                    ((info.size == 3'd2 && addr_q[0]) ||
                     (info.size == 3'd4 && addr_q[1:0] != 2'b00));
  assign eff_addr = addr_q;
`else
  assign misalign = 1'b0;
  always_comb begin
    eff_addr = addr_q;
    if (info.size == 3'd4)      eff_addr[1:0] = 2'b00;
    else if (info.size == 3'd2) eff_addr[0]   = 1'b0;
  end
`endif

  // The access happens on the BUSY cycle whose counter has reached zero,
  // provided the initiator has not withdrawn the request.
  assign exec = (state_q == S_BUSY) && (cnt_q == 4'd0) && bus.RAM_enable;

  always_comb begin
    mem_we    = 4'b0000;
    mem_wdata = din_q;
    case (info.size)
      3'd1:    mem_wdata = {din_q[7:0], 24'h0};
      3'd2:    mem_wdata = {din_q[15:0], 16'h0};
      default: mem_wdata = din_q;
    endcase
    if (exec && info.valid && info.is_store && !misalign) begin
      case (info.size)
        3'd1:    mem_we = 4'b0001;
        3'd2:    mem_we = 4'b0011;
        default: mem_we = 4'b1111;
      endcase
    end
  end

  always_comb begin
    load_data = mem_rdata;
    case (info.size)
      3'd1:    load_data = {{24{info.is_signed & mem_rdata[31]}}, mem_rdata[31:24]};
      3'd2:    load_data = {{16{info.is_signed & mem_rdata[31]}}, mem_rdata[31:16]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (bus.RAM_enable) begin
          op_d    = bus.RAM_OpCode;
          addr_d  = bus.Address;
          din_d   = bus.DataIn;
          cnt_d   = WS;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!bus.RAM_enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          mfc_d   = 1'b1;
          mis_d   = misalign;
          state_d = S_DONE;
          if (!info.valid || misalign) dout_d = 32'h0;
          else if (!info.is_store)     dout_d = load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (!bus.RAM_enable) begin
          mfc_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.DataOut  = dout_q;
  assign bus.MFC      = mfc_q;
  assign bus.MISALIGN = mis_q;

  sparc_mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (Clk),
    .addr  (eff_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
endmodule
